// File: rtl/mem_wb_stage_pkg.sv
// Shared constants for the MEM/WB stage: datapath widths, writeback-select
// codes, load funct3 codes and the load legality check.
package mem_wb_stage_pkg;

  localparam int DataWidth   = 32;
  localparam int AddrWidth   = 32;
  localparam int RegNumWidth = 5;

  // Writeback result source
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

  // Load types (funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // A load faults when misaligned for its size or when funct3 is not a load.
  function automatic logic load_fault_f(input logic [2:0] funct3,
                                        input logic [1:0] offset);
    logic f;
    case (funct3)
      F3_LB, F3_LBU: f = 1'b0;
      F3_LH, F3_LHU: f = offset[0];
      F3_LW:         f = (offset != 2'b00);
      default:       f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_aligner.sv
// Load-data formatter: picks the addressed byte/halfword lane out of the raw
// memory word and sign- or zero-extends it. Faulting loads return zero.
module load_aligner
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = DataWidth
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        offset,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] data,
  output logic              fault
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Split the word into its four byte lanes
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = rdata[8*gi +: 8];
    end
  endgenerate

  // Select lane, extend, and zero the result on a fault
  always_comb begin
    data     = '0;
    fault    = load_fault_f(funct3, offset);
    byte_sel = lane[offset];
    half_sel = offset[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};
    if (!fault) begin
      case (funct3)
        F3_LB:   data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
        F3_LBU:  data = {{(DATA_W-8){1'b0}}, byte_sel};
        F3_LH:   data = {{(DATA_W-16){half_sel[15]}}, half_sel};
        F3_LHU:  data = {{(DATA_W-16){1'b0}}, half_sel};
        F3_LW:   data = rdata;
        default: data = '0;
      endcase
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects and formats the writeback value, holds it
// for the register file write port, and counts retired instructions.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = DataWidth,
  parameter int ADDR_W = AddrWidth,
  parameter int REG_W  = RegNumWidth
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_reg_write,
  input  logic [1:0]        in_wb_sel,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_rdata,
  input  logic [2:0]        in_funct3,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              stall,
  input  logic              flush,
  output logic              regWriteEnable,
  output logic [REG_W-1:0]  regWriteNum,
  output logic [DATA_W-1:0] regWriteData,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_pc,
  output logic              load_fault,
  output logic [63:0]       instret
);

  logic [DATA_W-1:0] load_data;
  logic              load_fault_w;
  logic [DATA_W-1:0] sel_result;

  logic              valid_q, valid_d;
  logic              fresh_q, fresh_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              reg_write_q, reg_write_d;
  logic [1:0]        wb_sel_q, wb_sel_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        offset_q, offset_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [63:0]       instret_q, instret_d;

  load_aligner #(.DATA_W(DATA_W)) u_load_aligner (
    .rdata  (in_mem_rdata),
    .offset (in_alu_result[1:0]),
    .funct3 (in_funct3),
    .data   (load_data),
    .fault  (load_fault_w)
  );

  // Pick the writeback value ahead of the register
  always_comb begin
    sel_result = in_alu_result;
    case (in_wb_sel)
      WB_LOAD: sel_result = load_fault_w ? '0 : load_data;
      WB_PC4:  sel_result = DATA_W'(in_pc + ADDR_W'(4));
      WB_IMM:  sel_result = in_imm;
      default: sel_result = in_alu_result;
    endcase
  end

  // Next state: bubble beats hold, hold beats capture; a held instruction
  // stops being fresh once it has been counted on its first WB cycle
  always_comb begin
    valid_d     = valid_q;
    fresh_d     = fresh_q;
    pc_d        = pc_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    wb_sel_d    = wb_sel_q;
    funct3_d    = funct3_q;
    offset_d    = offset_q;
    result_d    = result_q;
    instret_d   = instret_q + 64'(valid_q & fresh_q);
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      fresh_d     = 1'b0;
    end else if (stall) begin
      fresh_d = 1'b0;
    end else begin
      valid_d     = in_valid;
      fresh_d     = in_valid;
      pc_d        = in_pc;
      rd_d        = in_rd;
      reg_write_d = in_reg_write;
      wb_sel_d    = in_wb_sel;
      funct3_d    = in_funct3;
      offset_d    = in_alu_result[1:0];
      result_d    = sel_result;
    end
  end

  // State register with synchronous reset overriding stall and flush
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      fresh_q     <= 1'b0;
      pc_q        <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      wb_sel_q    <= '0;
      funct3_q    <= '0;
      offset_q    <= '0;
      result_q    <= '0;
      instret_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      fresh_q     <= fresh_d;
      pc_q        <= pc_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      wb_sel_q    <= wb_sel_d;
      funct3_q    <= funct3_d;
      offset_q    <= offset_d;
      result_q    <= result_d;
      instret_q   <= instret_d;
    end
  end

  assign wb_valid       = valid_q;
  assign wb_pc          = pc_q;
  assign load_fault     = valid_q & (wb_sel_q == WB_LOAD) & load_fault_f(funct3_q, offset_q);
  assign regWriteEnable = valid_q & reg_write_q & (rd_q != '0) & ~load_fault;
  assign regWriteNum    = rd_q;
  assign regWriteData   = result_q;
  assign instret        = instret_q;

endmodule
